// File: rtl/fifo_burst_pkg.sv
// Shared types for the FIFO burst reader: FSM states, the word+last beat
// record carried through the skid buffer, and the buffer depth.
package fifo_burst_pkg;

  localparam int DATA_W     = 32;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FULL = 2'd1,
    PART = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/skid_buf_2.sv
// Two-entry valid/ready buffer for beat_t; occupancy is exported so the
// reader only issues FIFO reads that are guaranteed a slot.
module skid_buf_2
  import fifo_burst_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  input  beat_t      in_beat_i,
  output logic       out_valid_o,
  output beat_t      out_beat_o,
  input  logic       out_ready_i,
  output logic [1:0] count_o
);

  beat_t      ent0_q, ent1_q;
  logic [1:0] count_q;
  logic       pop;

  assign out_valid_o = (count_q != 2'd0);
  assign out_beat_o  = ent0_q;
  assign count_o     = count_q;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({in_valid_i, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= in_beat_i;
          else                 ent1_q <= in_beat_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_q <= in_beat_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= in_beat_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains sync_fifo and re-emits its words as valid/ready bursts framed by m_last.
// state | meaning
// IDLE  | waiting for a full burst, a flush, or the idle timeout
// FULL  | pipelined reads of exactly BURST_LEN words
// PART  | one-at-a-time reads until the FIFO runs dry or BURST_LEN is hit
// DONE  | no reads; wait for the last-tagged beat to leave
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = $clog2(BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_pro_empty,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy
);

  localparam int TO_W = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic             inflight_q, rd_tag_q, rd_part_q;

  logic [1:0] skid_cnt;
  logic [2:0] occ;
  logic       pop, read_allowed, last_issue, ret_last;
  beat_t      in_beat, out_beat;

  // Occupancy once this cycle's transfer leaves; counting the pop keeps FULL at 1 beat/cycle.
  assign pop          = m_valid & m_ready;
  assign occ          = 3'(skid_cnt) + 3'(inflight_q) - 3'(pop);
  assign read_allowed = (state_q == FULL) | ((state_q == PART) & ~inflight_q);
  assign fifo_rd_en   = read_allowed & ~fifo_empty & (occ < 3'(SKID_DEPTH));
  assign last_issue   = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign ret_last     = rd_tag_q | (rd_part_q & fifo_empty);

  assign in_beat.last = ret_last;
  assign in_beat.data = DATA_W'(fifo_data_out);
  assign m_data       = DATA_WIDTH'(out_beat.data);
  assign m_last       = out_beat.last;
  assign busy         = (state_q != IDLE);

  skid_buf_2 u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (inflight_q),
    .in_beat_i   (in_beat),
    .out_valid_o (m_valid),
    .out_beat_o  (out_beat),
    .out_ready_i (m_ready),
    .count_o     (skid_cnt)
  );

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        timeout_d = fifo_empty ? '0 : timeout_q + TO_W'(1);
        if (!fifo_pro_empty) begin
          state_d    = FULL;
          beat_cnt_d = '0;
          timeout_d  = '0;
        end else if (!fifo_empty && (flush || timeout_q == TO_W'(TIMEOUT - 1))) begin
          state_d    = PART;
          beat_cnt_d = '0;
          timeout_d  = '0;
        end
      end
      FULL: begin
        if (fifo_rd_en) begin
          if (last_issue) begin
            beat_cnt_d = '0;
            state_d    = DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      PART: begin
        if (fifo_rd_en) beat_cnt_d = last_issue ? '0 : beat_cnt_q + CNT_W'(1);
        if (inflight_q && ret_last) begin
          beat_cnt_d = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (pop && m_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      timeout_q  <= '0;
      inflight_q <= 1'b0;
      rd_tag_q   <= 1'b0;
      rd_part_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      timeout_q  <= timeout_d;
      inflight_q <= fifo_rd_en;
      rd_tag_q   <= fifo_rd_en & last_issue;
      rd_part_q  <= fifo_rd_en & (state_q == PART);
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a behavioural sync_fifo in front.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fifo_data_out = '0;
  logic        fifo_empty, fifo_pro_empty, fifo_rd_en;
  logic        flush = 1'b0;
  logic [31:0] m_data;
  logic        m_valid, m_last, busy;
  logic        m_ready = 1'b1;

  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_pro_empty (fifo_pro_empty),
    .fifo_rd_en     (fifo_rd_en),
    .flush          (flush),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .busy           (busy)
  );

  // Behavioural FIFO: 64 deep, one-cycle read latency, pro_empty below 16 words.
  logic [31:0] mem [0:63];
  logic [6:0]  wr_ptr = '0, rd_ptr = '0, f_count;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;

  assign f_count        = wr_ptr - rd_ptr;
  assign fifo_empty     = (f_count == 7'd0);
  assign fifo_pro_empty = (f_count < 7'd16);

  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[5:0]] <= wr_data;
      wr_ptr <= wr_ptr + 7'd1;
    end
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 7'd1;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   xfer_times[$];
  int   vectors = 0, fails = 0;
  int   cyc = 0, beats_seen = 0;
  int   rd_iss = 0, xfers = 0;
  logic any_rd = 1'b0, rd_empty_viol = 1'b0, credit_viol = 1'b0;
  logic hold_pend = 1'b0, hold_l = 1'b0;
  logic [31:0] hold_d = '0;
  int   rdy_mode = 0;
  logic [3:0] rdy_pat = 4'b1001;
  int   rdy_phase = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1: begin
        m_ready = rdy_pat[3 - (rdy_phase % 4)];
        rdy_phase = rdy_phase + 1;
      end
      2:       m_ready = 1'b0;
      default: m_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_iss    = 0;
      xfers     = 0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        vectors++;
        if (!m_valid || m_data !== hold_d || m_last !== hold_l) begin
          fails++;
          $display("FAIL hold_stable: got valid=%0b data=%0d last=%0b, need valid=1 data=%0d last=%0b",
                   m_valid, m_data, m_last, hold_d, hold_l);
        end
      end
      hold_pend = m_valid && !m_ready;
      hold_d    = m_data;
      hold_l    = m_last;
      if (fifo_rd_en) begin
        any_rd = 1'b1;
        if (fifo_empty) rd_empty_viol = 1'b1;
        if (rd_iss - xfers - int'(m_valid && m_ready) >= 2) credit_viol = 1'b1;
      end
      if (m_valid && m_ready) begin
        vectors++;
        beats_seen++;
        xfer_times.push_back(cyc);
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: got data=%0d last=%0b, need no beat", m_data, m_last);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (m_data !== e.data || m_last !== e.last) begin
            fails++;
            $display("FAIL beat: got data=%0d last=%0b, need data=%0d last=%0b",
                     m_data, m_last, e.data, e.last);
          end
        end
      end
      rd_iss += int'(fifo_rd_en);
      xfers  += int'(m_valid && m_ready);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] base, input int n, input int last_every);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data = base + 32'(i);
      e.last = ((i % last_every) == last_every - 1) || (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic write_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = base + 32'(i);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_remaining", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_last"},  64'(m_last),  64'd0);
    chk({tag, "_m_data"},  64'(m_data),  64'd0);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_rd_en"},   64'(fifo_rd_en), 64'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Two back-to-back full bursts at full rate.
    rdy_mode = 0;
    xfer_times.delete();
    push_exp(32'd512, 32, 16);
    write_words(32'd512, 32);
    wait_drain(300);
    repeat (2) @(posedge clk);
    #1;
    chk("full_busy_after", 64'(busy), 64'd0);
    chk("full_beats", 64'(xfer_times.size()), 64'd32);
    if (xfer_times.size() == 32) begin
      chk("full_rate_b0", 64'(xfer_times[15] - xfer_times[0]), 64'd15);
      chk("full_rate_b1", 64'(xfer_times[31] - xfer_times[16]), 64'd15);
    end

    // Back-pressure 1,0,0,1.
    credit_viol = 1'b0;
    rdy_mode = 1;
    push_exp(32'd200, 16, 16);
    write_words(32'd200, 16);
    wait_drain(300);
    chk("bp_credit_viol", 64'(credit_viol), 64'd0);
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;

    // Idle timeout drains a short burst.
    any_rd = 1'b0;
    push_exp(32'd100, 5, 16);
    write_words(32'd100, 5);
    repeat (50) @(posedge clk);
    #1;
    chk("timeout_early_read", 64'(any_rd), 64'd0);
    wait_drain(200);
    repeat (4) @(posedge clk);
    #1;

    // Flush with residual data, then flush with an empty FIFO.
    push_exp(32'd40, 3, 16);
    write_words(32'd40, 3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_drain(60);
    repeat (3) @(posedge clk);
    #1;
    any_rd = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("empty_flush_read", 64'(any_rd), 64'd0);
    chk("empty_flush_busy", 64'(busy), 64'd0);

    // Exactly 16 words, flush coincides with pro_empty falling: FULL mode wins.
    rd_empty_viol = 1'b0;
    xfer_times.delete();
    push_exp(32'd700, 16, 16);
    write_words(32'd700, 16);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_drain(100);
    chk("bnd_beats", 64'(xfer_times.size()), 64'd16);
    if (xfer_times.size() == 16)
      chk("bnd_full_rate", 64'(xfer_times[15] - xfer_times[0]), 64'd15);
    chk("bnd_rd_while_empty", 64'(rd_empty_viol), 64'd0);
    repeat (4) @(posedge clk);
    #1;

    // Reset after 7 beats, then a fresh burst from the FIFO head.
    rdy_mode = 2;
    push_exp(32'd300, 16, 16);
    write_words(32'd300, 32);
    base = beats_seen;
    rdy_mode = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (beats_seen - base >= 7) break;
    end
    chk("rst_seven_beats", 64'(beats_seen - base), 64'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      logic [6:0] p;
      p = rd_ptr + 7'(i);
      e.data = mem[p[5:0]];
      e.last = (i == 15);
      sb.push_back(e);
    end
    wait_drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
